// File: rtl/adaptive_threshold_pkg.sv
// Shared constants and state encoding for the adaptive threshold stage.
package adaptive_threshold_pkg;

    localparam int DEFAULT_WIDTH_BITS  = 8;
    localparam int DEFAULT_HEIGHT_BITS = 8;
    localparam int PIXEL_BITS          = 8;

    localparam logic [PIXEL_BITS-1:0] FG_VALUE = 8'hFF;
    localparam logic [PIXEL_BITS-1:0] BG_VALUE = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/adaptive_threshold_pixel_delay_line.sv
// Fixed-depth shift register carrying a valid bit and a pixel position alongside
// memory read data; every stage's valid bit is exposed so callers can detect an empty pipe.
module pixel_delay_line #(
    parameter int DEPTH     = 2,
    parameter int DATA_BITS = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic [DEPTH-1:0]     valid_taps,
    output logic [DATA_BITS-1:0] out_data
);

    logic [DATA_BITS-1:0] data_q [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_taps <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_taps[0] <= in_valid;
            data_q[0]     <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                valid_taps[i] <= valid_taps[i-1];
                data_q[i]     <= data_q[i-1];
            end
        end
    end

    assign out_data = data_q[DEPTH-1];

endmodule

// File: rtl/adaptive_threshold.sv
// Adaptive threshold: streams original and mean images in lock-step and writes pixel > mean - OFFSET
// as a 0/255 image. Define ADAPTIVE_THRESHOLD_COUNT_EN to add the oForegroundCount output.
module adaptive_threshold
    import adaptive_threshold_pkg::*;
#(
    parameter int WIDTH_BITS   = DEFAULT_WIDTH_BITS,
    parameter int HEIGHT_BITS  = DEFAULT_HEIGHT_BITS,
    parameter int OFFSET       = 5,
    parameter int READ_LATENCY = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    output logic [WIDTH_BITS-1:0]  oImageCol,
    output logic [HEIGHT_BITS-1:0] oImageRow,
    input  logic [PIXEL_BITS-1:0]  iImageData,
    output logic [WIDTH_BITS-1:0]  oMeanCol,
    output logic [HEIGHT_BITS-1:0] oMeanRow,
    input  logic [PIXEL_BITS-1:0]  iMeanData,
    output logic [WIDTH_BITS-1:0]  oResultCol,
    output logic [HEIGHT_BITS-1:0] oResultRow,
    output logic [PIXEL_BITS-1:0]  oResultData,
    output logic                   oResultWren,
    output logic                   busy,
    output logic                   finished
`ifdef ADAPTIVE_THRESHOLD_COUNT_EN
    ,
    output logic [WIDTH_BITS+HEIGHT_BITS:0] oForegroundCount
`endif
);

    localparam int POS_BITS = WIDTH_BITS + HEIGHT_BITS;
    localparam int DEPTH    = READ_LATENCY + 1;
    localparam logic [POS_BITS-1:0]     LAST_POS   = '1;
    localparam logic [PIXEL_BITS+1:0]   OFFSET_EXT = (PIXEL_BITS+2)'(OFFSET);

    state_t              state;
    state_t              state_next;
    logic [POS_BITS-1:0] pos;
    logic [POS_BITS-1:0] write_pos;
    logic [DEPTH-1:0]    valid_taps;
    logic                issue_valid;
    logic                run_entry;
    logic                pipe_empty;
    logic                align_valid;
    logic                is_fg;

    assign run_entry = ((state == IDLE) || (state == DONE)) && start;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DRAIN ends once only the output stage still holds a write, so DONE follows the last strobe.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (pos == LAST_POS) state_next = DRAIN;
            DRAIN:   if (pipe_empty) state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        finished    = 1'b0;
        issue_valid = 1'b0;
        case (state)
            RUN: begin
                busy        = 1'b1;
                issue_valid = 1'b1;
            end
            DRAIN:   busy = 1'b1;
            DONE:    finished = 1'b1;
            default: ;
        endcase
    end

    // Saturates at the last pixel so DRAIN keeps pointing at N-1 instead of wrapping to 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pos <= '0;
        end else if (run_entry) begin
            pos <= '0;
        end else if ((state == RUN) && (pos != LAST_POS)) begin
            pos <= pos + POS_BITS'(1);
        end
    end

    assign oImageCol = pos[WIDTH_BITS-1:0];
    assign oImageRow = pos[POS_BITS-1:WIDTH_BITS];
    assign oMeanCol  = pos[WIDTH_BITS-1:0];
    assign oMeanRow  = pos[POS_BITS-1:WIDTH_BITS];

    pixel_delay_line #(
        .DEPTH     (DEPTH),
        .DATA_BITS (POS_BITS)
    ) u_delay (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (issue_valid),
        .in_data    (pos),
        .valid_taps (valid_taps),
        .out_data   (write_pos)
    );

    assign align_valid = valid_taps[DEPTH-2];
    assign pipe_empty  = (valid_taps[DEPTH-2:0] == '0);
    assign is_fg       = ({2'b00, iImageData} + OFFSET_EXT) > {2'b00, iMeanData};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            oResultData <= BG_VALUE;
        end else if (align_valid) begin
            oResultData <= is_fg ? FG_VALUE : BG_VALUE;
        end
    end

    assign oResultWren = valid_taps[DEPTH-1];
    assign oResultCol  = write_pos[WIDTH_BITS-1:0];
    assign oResultRow  = write_pos[POS_BITS-1:WIDTH_BITS];

`ifdef ADAPTIVE_THRESHOLD_COUNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            oForegroundCount <= '0;
        end else if (run_entry) begin
            oForegroundCount <= '0;
        end else if (oResultWren && (oResultData == FG_VALUE)) begin
            oForegroundCount <= oForegroundCount + (POS_BITS+1)'(1);
        end
    end
`endif

endmodule

// File: doc/adaptive_threshold.md
Name: adaptive_threshold

Overview:
- Stage directly downstream of the 3x3 box-mean stage.
- Once the mean image is complete, streams the original image and the mean image in lock-step, one pixel per clock.
- Compares each pixel against its local mean minus a fixed offset and writes a binary image (0/255) to the result memory.
- Provides the start/finished handshake used to sequence the pipeline.

Parameters:
- WIDTH_BITS, 8, log2 of image width.
- HEIGHT_BITS, 8, log2 of image height.
- OFFSET, 5, constant C in the rule "pixel > mean - C"; legal range 0..255.
- READ_LATENCY, 1, clocks from address to data for both source memories; legal range 1..3.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled in IDLE/DONE, normally driven from the box stage's finished.
- oImageCol  out  WIDTH_BITS  original-image read column.
- oImageRow  out  HEIGHT_BITS  original-image read row.
- iImageData  in  8  original pixel, valid READ_LATENCY clocks after address.
- oMeanCol  out  WIDTH_BITS  mean-image read column; always equals oImageCol.
- oMeanRow  out  HEIGHT_BITS  mean-image read row; always equals oImageRow.
- iMeanData  in  8  mean pixel, same latency as iImageData.
- oResultCol  out  WIDTH_BITS  result write column.
- oResultRow  out  HEIGHT_BITS  result write row.
- oResultData  out  8  8'hFF foreground, 8'h00 background.
- oResultWren  out  1  result write strobe, one clock per pixel.
- busy  out  1  high in RUN and DRAIN.
- finished  out  1  high in DONE.

Behaviour:
- Reset (reset=0, asynchronous) clears everything immediately:
  - state=IDLE; read position=0.
  - oResultWren=0, oResultData=0, oResultCol/Row=0.
  - busy=0, finished=0; all pipeline valid bits=0.
- Pixel order: raster scan, row-major; position = {row, col}; N = 2^(WIDTH_BITS+HEIGHT_BITS).
- States:
  - IDLE: read addresses held at 0. start=1 -> RUN.
  - RUN: each clock issues the address of pixel k (k=0..N-1, +1 per clock, no stalls). After issuing k=N-1 -> DRAIN.
  - DRAIN: no new addresses (held at N-1); waits until the pipeline is empty, then -> DONE.
  - DONE: finished=1. start=1 -> RUN with position=0 and finished cleared the same edge.
- start is ignored while busy=1.
- Timing, with cycle 0 being the first RUN clock:
  - Address of pixel k is driven in cycle k.
  - Pixel-k data is valid in cycle k+READ_LATENCY.
  - oResultWren=1 with pixel k's coordinates and result in cycle k+READ_LATENCY+1.
  - The last write is in cycle N+READ_LATENCY; finished=1 from cycle N+READ_LATENCY+1.
- oResultWren is registered and pulses exactly N times per run, with no gaps.
- Compare rule: foreground iff {2'b0,pixel} + OFFSET > {2'b0,mean}, evaluated 10 bits wide.
  - No underflow or overflow is possible.
  - Equality gives background.
- Position and valid travel READ_LATENCY+1 clocks through a delay line alongside the read data. Write coordinates come only from that delayed position, never from the live counter.
- Wrap-around: the position counter stops at N-1 and never wraps into pixel 0 during DRAIN.
- Reset mid-run: pending writes are discarded. No write strobe may appear after reset deasserts until a new start.

Optional Feature:
- ADAPTIVE_THRESHOLD_COUNT_EN defined:
  - Adds output oForegroundCount, width WIDTH_BITS+HEIGHT_BITS+1.
  - Cleared on reset and on each RUN entry.
  - Increments on every write with oResultData=8'hFF.
  - Stable and valid while finished=1.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - default WIDTH_BITS/HEIGHT_BITS;
  - pixel width constant (8);
  - FG_VALUE=8'hFF, BG_VALUE=8'h00;
  - state encoding IDLE/RUN/DRAIN/DONE.
- One sub-module: pixel_delay_line, a parameterised depth shift register carrying {valid, position} READ_LATENCY+1 stages. Reused later for other streaming stages.

Test Plan:
- Setup for all scenarios: WIDTH_BITS=HEIGHT_BITS=2 (N=16), OFFSET=5.
- Uniform image 100, mean 100, READ_LATENCY=1:
  - All 16 writes carry 8'hFF.
  - First oResultWren in cycle 2, last in cycle 17, finished in cycle 18.
- Equality boundary, mean 100: pixel 95 -> 8'h00, pixel 96 -> 8'hFF, pixel 90 -> 8'h00.
- Underflow guard: mean 3, pixel 0 -> 8'hFF; mean 255, pixel 250 -> 8'h00.
- Write ordering/addressing, image value = index k, mean = k+10 (OFFSET=15):
  - Every pixel is foreground.
  - Write coordinates run (0,0),(1,0)..(3,3) in order.
  - Repeat with READ_LATENCY=3: first write in cycle 4.
- Handshake:
  - start pulsed again mid-RUN -> ignored, exactly 16 writes.
  - start in DONE -> second full run, finished drops on that edge.
- reset=0 at cycle 7 -> outputs clear immediately; no writes until the next start. COUNT_EN build: half-foreground image -> oForegroundCount=8.
